// File: rtl/c_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module   : c_drain_pkg
// Brief    : Shared types and width helper for the C tile drain stage.
// Revision : 1.0
// ============================================================================
package c_drain_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_CV = 3'd1,
    S_REQ     = 3'd2,
    S_GAP     = 3'd3,
    S_EMIT    = 3'd4,
    S_DONE    = 3'd5
  } drain_state_t;

  // Address width that never collapses to zero for single-entry dimensions.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/c_tile_drain.sv
`default_nettype none
// ============================================================================
// Module   : c_tile_drain
// Brief    : Reads an M x N C tile element by element and streams packed rows.
// Revision : 1.0
// ============================================================================
module c_tile_drain
  import c_drain_pkg::*;
#(
  parameter  int M              = 8,
  parameter  int N              = 8,
  parameter  int DATA_W         = 32,
  parameter  int RVALID_TIMEOUT = 1024,
  localparam int ROW_W          = clog2_min1(M),
  localparam int COL_W          = clog2_min1(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                c_valid_i,
  output logic                mem_en,
  output logic                mem_re,
  output logic [ROW_W-1:0]    mem_row,
  output logic [COL_W-1:0]    mem_col,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rvalid,
  output logic [N*DATA_W-1:0] m_data,
  output logic [ROW_W-1:0]    m_row,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int TMO_W = $clog2(RVALID_TIMEOUT + 1);
  localparam logic [ROW_W-1:0] C_ROW_LAST = ROW_W'(M - 1);
  localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(N - 1);
  localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(RVALID_TIMEOUT - 1);

  drain_state_t      r_state;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic [TMO_W-1:0]  r_tmo;
  logic [DATA_W-1:0] r_buf [N];
  logic              r_mem_en;
  logic              r_m_valid;
  logic              r_m_last;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_row     <= '0;
      r_col     <= '0;
      r_tmo     <= '0;
      r_mem_en  <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      for (int j = 0; j < N; j++) begin
        r_buf[j] <= '0;
      end
    end else if (abort) begin
      // Cancel leaves err and the counters alone; a new start re-initialises them.
      r_state   <= S_IDLE;
      r_mem_en  <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= S_WAIT_CV;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
            r_row   <= '0;
            r_col   <= '0;
          end
        end
        S_WAIT_CV: begin
          if (c_valid_i) begin
            r_state  <= S_REQ;
            r_mem_en <= 1'b1;
            r_tmo    <= '0;
          end
        end
        S_REQ: begin
          if (mem_rvalid) begin
            r_buf[r_col] <= mem_rdata;
            r_mem_en     <= 1'b0;
            r_state      <= S_GAP;
          end else if (r_tmo == C_TMO_LAST) begin
            r_err    <= 1'b1;
            r_mem_en <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_GAP: begin
          if (r_col == C_COL_LAST) begin
            r_state   <= S_EMIT;
            r_m_valid <= 1'b1;
            r_m_last  <= (r_row == C_ROW_LAST);
          end else begin
            r_col    <= r_col + 1'b1;
            r_tmo    <= '0;
            r_mem_en <= 1'b1;
            r_state  <= S_REQ;
          end
        end
        S_EMIT: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            if (r_row == C_ROW_LAST) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_row    <= r_row + 1'b1;
              r_col    <= '0;
              r_tmo    <= '0;
              r_mem_en <= 1'b1;
              r_state  <= S_REQ;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_en  <= 1'b0;
          r_m_valid <= 1'b0;
          r_m_last  <= 1'b0;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  generate
    for (genvar j = 0; j < N; j++) begin : g_pack
      assign m_data[j*DATA_W +: DATA_W] = r_buf[j];
    end
  endgenerate

  assign mem_en  = r_mem_en;
  assign mem_re  = r_mem_en;
  assign mem_row = r_row;
  assign mem_col = r_col;
  assign m_row   = r_row;
  assign m_valid = r_m_valid;
  assign m_last  = r_m_last;
  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_c_tile_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_c_tile_drain
// Brief    : Directed self-checking bench for c_tile_drain with a latency-2 memory.
// Revision : 1.0
// ============================================================================
module tb_c_tile_drain;

  localparam int M   = 8;
  localparam int N   = 8;
  localparam int DW  = 32;
  localparam int TMO = 16;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n, start, abort, c_valid_i, m_ready;
  logic          mem_en, mem_re, m_valid, m_last, busy, done, err;
  logic [2:0]    mem_row, mem_col, m_row;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_rvalid = 1'b0;
  logic [N*DW-1:0] m_data;
  logic          mem_stall;
  int            mem_cnt = 0;
  int            n_checks = 0;
  int            n_pass = 0;
  int            n_done = 0;
  bit            re_bad = 0;

  always #5 clk = ~clk;

  c_tile_drain #(.M(M), .N(N), .DATA_W(DW), .RVALID_TIMEOUT(TMO)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .c_valid_i(c_valid_i),
    .mem_en(mem_en), .mem_re(mem_re), .mem_row(mem_row), .mem_col(mem_col),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .m_data(m_data), .m_row(m_row), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .busy(busy), .done(done), .err(err)
  );

  // Memory holding C[i][j] = 100*i + j, answering LAT cycles after mem_en rises.
  always @(posedge clk) begin
    if (!mem_en || mem_stall) begin
      mem_cnt    <= 0;
      mem_rvalid <= 1'b0;
    end else if (mem_rvalid) begin
      mem_rvalid <= 1'b0;
    end else if (mem_cnt == LAT - 1) begin
      mem_rvalid <= 1'b1;
      mem_rdata  <= DW'(100 * int'(mem_row) + int'(mem_col));
    end else begin
      mem_cnt <= mem_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (done) n_done++;
    if (mem_re !== mem_en) re_bad = 1;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [255:0] exp_row(input int r);
    logic [255:0] v;
    v = '0;
    for (int j = 0; j < N; j++) v[j*DW +: DW] = DW'(100 * r + j);
    return v;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_row(output bit ok);
    ok = 0;
    for (int k = 0; k < 400; k++) begin
      if (m_valid) begin
        ok = 1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic drain(input int n_rows, input int stall_row, input string tag);
    bit ok;
    bit stable;
    logic [255:0] held;
    int d0;
    d0 = n_done;
    m_ready = 1'b1;
    for (int r = 0; r < n_rows; r++) begin
      if (r == stall_row) m_ready = 1'b0;
      wait_row(ok);
      if (!ok) begin
        check({tag, "_row_timeout"}, 0, 1);
        m_ready = 1'b1;
        return;
      end
      check({tag, "_m_row"}, m_row, r);
      check({tag, "_m_data"}, m_data, exp_row(r));
      check({tag, "_m_last"}, m_last, (r == M - 1));
      if (r == stall_row) begin
        held   = m_data;
        stable = 1;
        repeat (10) begin
          @(negedge clk);
          if (!(m_valid && m_data == held && m_row == 3'(r) && !mem_en)) stable = 0;
        end
        check({tag, "_stall_stable"}, stable, 1);
        m_ready = 1'b1;
      end
      @(negedge clk);
    end
    if (n_rows == M) begin
      repeat (3) @(negedge clk);
      check({tag, "_done_pulses"}, n_done - d0, 1);
      check({tag, "_busy_after"}, busy, 0);
      check({tag, "_err_after"}, err, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int cnt;
    int d0;
    bit bad;
    rst_n = 0; start = 0; abort = 0; c_valid_i = 0; m_ready = 0; mem_stall = 0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {mem_en, mem_re, mem_row, mem_col, m_row, m_valid, m_last, busy, done, err}, 0);
    check("reset_data", m_data, 0);
    rst_n = 1;
    @(negedge clk);

    // Nominal drain
    c_valid_i = 1;
    pulse_start();
    check("nom_busy", busy, 1);
    drain(M, -1, "nom");
    check("mem_re_eq_en", re_bad, 0);

    // Backpressure on row 3
    pulse_start();
    drain(M, 3, "bp");

    // Start well before c_valid
    c_valid_i = 0;
    pulse_start();
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_en) bad = 1;
    end
    check("cv_no_req", bad, 0);
    check("cv_busy", busy, 1);
    c_valid_i = 1;
    check("cv_en_same", mem_en, 0);
    @(negedge clk);
    check("cv_en_next", mem_en, 1);
    drain(M, -1, "cv");

    // Read timeout
    mem_stall = 1;
    d0 = n_done;
    pulse_start();
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      if (mem_en) cnt++;
      if (!busy) break;
      @(negedge clk);
    end
    check("tmo_req_cycles", cnt, TMO);
    check("tmo_err", err, 1);
    check("tmo_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("tmo_no_done", n_done - d0, 0);
    mem_stall = 0;
    pulse_start();
    check("tmo_err_cleared", err, 0);
    drain(M, -1, "tmo_re");

    // Abort during row 2 request
    pulse_start();
    drain(2, -1, "ab");
    check("ab_req_row2", {mem_en, mem_row}, {1'b1, 3'd2});
    d0 = n_done;
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("ab_outputs", {busy, m_valid, mem_en}, 0);
    check("ab_err", err, 0);
    repeat (3) @(negedge clk);
    check("ab_no_done", n_done - d0, 0);
    pulse_start();
    drain(M, -1, "ab_re");

    // Reset while row 0 is presented
    m_ready = 0;
    pulse_start();
    wait_row(ok);
    check("rst_emit_seen", ok, 1);
    rst_n = 0;
    start = 1;
    @(negedge clk);
    check("rst_ctrl", {mem_en, mem_re, mem_row, mem_col, m_row, m_valid, m_last, busy, done, err}, 0);
    check("rst_data", m_data, 0);
    @(negedge clk);
    check("rst_start_ignored", busy, 0);
    rst_n = 1;
    start = 0;
    @(negedge clk);
    check("rst_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
